// File: rtl/qbus_dl11_mux.sv
// Multi-channel DL11-style serial slave on the QBUS: RCSR/RBUF/XCSR/XBUF per channel,
// paced transmitter, vectored interrupts with IAK daisy chain. Optional RX FIFO: QBUS_DL11_MUX_RXFIFO_EN.
module qbus_dl11_mux #(
    parameter int          CHAN   = 2,
    parameter logic [15:0] BASE   = 16'o177560,
    parameter logic [15:0] VEC    = 16'o000060,
    parameter int          TX_DIV = 500,
    parameter int          RX_AW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       ad_n,
    output logic [15:0]       ad_out_n,
    output logic              ad_oe,
    input  logic              sync_n,
    input  logic              din_n,
    input  logic              dout_n,
    input  logic              wtbt_n,
    output logic              rply_n,
    output logic              virq_n,
    input  logic              iaki_n,
    output logic              iako_n,
    output logic [8*CHAN-1:0] tx_data,
    output logic [CHAN-1:0]   tx_stb,
    input  logic [8*CHAN-1:0] rx_data,
    input  logic [CHAN-1:0]   rx_stb
);
    localparam int CW = $clog2(TX_DIV);
    localparam int IW = (CHAN > 1) ? $clog2(CHAN) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RDR, S_WR, S_WRR} state_t;
    state_t state;

    logic            sync_q, pop_req, iak_own, win_tx, any_pend;
    logic [15:0]     addr, rdata, wdata, vector;
    logic [12:0]     off;
    logic            sel;
    logic [IW-1:0]   ch, pop_ch, win_ch;
    logic [1:0]      rg;
    logic [CHAN-1:0] rie, xie, rdy, tx_pend, rx_pend, pop, done_v, head_ovr;
    logic [7:0]      head [CHAN];
    logic [CW-1:0]   cnt [CHAN];

    assign off    = addr[15:3] - BASE[15:3];
    assign sel    = off < 13'(CHAN);
    assign ch     = off[IW-1:0];
    assign rg     = addr[2:1];
    assign wdata  = ~ad_n;
    assign vector = VEC + 16'({win_ch, win_tx, 2'b00});

`ifdef QBUS_DL11_MUX_RXFIFO_EN
    localparam int DEPTH = 1 << RX_AW;
    logic [7:0]       mem  [CHAN][DEPTH];
    logic [DEPTH-1:0] movr [CHAN];
    logic [RX_AW:0]   wp   [CHAN];
    logic [RX_AW:0]   rp   [CHAN];

    always_comb begin
        for (int i = 0; i < CHAN; i++) begin
            done_v[i]   = wp[i] != rp[i];
            head[i]     = mem[i][rp[i][RX_AW-1:0]];
            head_ovr[i] = movr[i][rp[i][RX_AW-1:0]];
        end
    end

    // Pop is applied before the push, so a full FIFO being read still accepts the new byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHAN; i++) begin
                wp[i] <= '0;
                rp[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHAN; i++) begin
                if (pop[i] && done_v[i]) rp[i] <= rp[i] + 1'b1;
                if (rx_stb[i]) begin
                    if ((wp[i] - rp[i]) != (RX_AW+1)'(DEPTH) || pop[i]) begin
                        mem[i][wp[i][RX_AW-1:0]]  <= rx_data[8*i +: 8];
                        movr[i][wp[i][RX_AW-1:0]] <= 1'b0;
                        wp[i] <= wp[i] + 1'b1;
                    end else begin
                        movr[i][wp[i][RX_AW-1:0] - 1'b1] <= 1'b1;
                    end
                end
            end
        end
    end
`else
    logic [7:0]      hold [CHAN];
    logic [CHAN-1:0] full_r, ovr_r;

    always_comb begin
        for (int i = 0; i < CHAN; i++) head[i] = hold[i];
        done_v   = full_r;
        head_ovr = ovr_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_r <= '0;
            ovr_r  <= '0;
        end else begin
            for (int i = 0; i < CHAN; i++) begin
                if (rx_stb[i]) begin
                    hold[i]   <= rx_data[8*i +: 8];
                    full_r[i] <= 1'b1;
                    ovr_r[i]  <= full_r[i] & ~pop[i];
                end else if (pop[i]) begin
                    full_r[i] <= 1'b0;
                    ovr_r[i]  <= 1'b0;
                end
            end
        end
    end
`endif

    assign rx_pend  = done_v & rie;
    assign any_pend = |{rx_pend, tx_pend};

    always_comb begin
        pop = '0;
        if ((state == S_RD || state == S_RDR) && din_n && pop_req) pop[pop_ch] = 1'b1;
    end

    // Scan high to low so the lowest channel wins; RX overrides TX within a channel.
    always_comb begin
        win_ch = '0;
        win_tx = 1'b0;
        for (int i = CHAN - 1; i >= 0; i--) begin
            if (tx_pend[i]) begin win_ch = IW'(i); win_tx = 1'b1; end
            if (rx_pend[i]) begin win_ch = IW'(i); win_tx = 1'b0; end
        end
    end

    always_comb begin
        rdata = '0;
        case (rg)
            2'd0:    rdata[7:6] = {done_v[ch], rie[ch]};
            2'd1:    rdata = {head_ovr[ch], 7'd0, head[ch]};
            2'd2:    rdata[7:6] = {rdy[ch], xie[ch]};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sync_q   <= 1'b1;
            addr     <= '0;
            ad_oe    <= 1'b0;
            ad_out_n <= '1;
            rply_n   <= 1'b1;
            virq_n   <= 1'b1;
            iako_n   <= 1'b1;
            iak_own  <= 1'b0;
            pop_req  <= 1'b0;
            pop_ch   <= '0;
            tx_stb   <= '0;
            tx_data  <= '0;
            rie      <= '0;
            xie      <= '0;
            rdy      <= '1;
            tx_pend  <= '0;
            for (int i = 0; i < CHAN; i++) cnt[i] <= '0;
        end else begin
            sync_q  <= sync_n;
            if (sync_q && !sync_n) addr <= ~ad_n;
            tx_stb  <= '0;
            virq_n  <= ~any_pend;
            iako_n  <= iaki_n | any_pend | iak_own;
            iak_own <= iak_own & ~iaki_n;
            for (int i = 0; i < CHAN; i++) begin
                if (!rdy[i]) begin
                    if (cnt[i] == '0) begin
                        rdy[i] <= 1'b1;
                        if (xie[i]) tx_pend[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] - 1'b1;
                    end
                end
            end
            case (state)
                S_IDLE: begin
                    if (!sync_n && sel && !din_n) begin
                        ad_oe    <= 1'b1;
                        ad_out_n <= ~rdata;
                        pop_req  <= rg == 2'd1;
                        pop_ch   <= ch;
                        state    <= S_RD;
                    end else if (!sync_n && sel && !dout_n) begin
                        state <= S_WR;
                        // An odd-byte write touches only the high byte, which holds nothing writable.
                        if (wtbt_n || !addr[0]) begin
                            case (rg)
                                2'd0: rie[ch] <= wdata[6];
                                2'd2: begin
                                    xie[ch] <= wdata[6];
                                    if (!wdata[6]) tx_pend[ch] <= 1'b0;
                                    else if (!xie[ch] && rdy[ch]) tx_pend[ch] <= 1'b1;
                                end
                                2'd3: if (rdy[ch]) begin
                                    tx_data[8*ch +: 8] <= wdata[7:0];
                                    tx_stb[ch]  <= 1'b1;
                                    rdy[ch]     <= 1'b0;
                                    cnt[ch]     <= CW'(TX_DIV - 1);
                                    tx_pend[ch] <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end else if (sync_n && !iaki_n && !din_n && any_pend) begin
                        ad_oe    <= 1'b1;
                        ad_out_n <= ~vector;
                        pop_req  <= 1'b0;
                        iak_own  <= 1'b1;
                        iako_n   <= 1'b1;
                        if (win_tx) tx_pend[win_ch] <= 1'b0;
                        state    <= S_RD;
                    end
                end
                S_RD, S_RDR: begin
                    if (din_n) begin
                        ad_oe    <= 1'b0;
                        ad_out_n <= '1;
                        rply_n   <= 1'b1;
                        pop_req  <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        rply_n <= 1'b0;
                        state  <= S_RDR;
                    end
                end
                S_WR: begin
                    if (dout_n) begin
                        state <= S_IDLE;
                    end else begin
                        rply_n <= 1'b0;
                        state  <= S_WRR;
                    end
                end
                S_WRR: begin
                    if (dout_n) begin
                        rply_n <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qbus_dl11_mux.sv
// Directed bench for qbus_dl11_mux: bus reads/writes, TX pacing, RX overrun, IAK vectors, reset.
module tb_qbus_dl11_mux;
    localparam int TXD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ad_n = '1;
    logic [15:0] ad_out_n;
    logic        ad_oe, rply_n, virq_n, iako_n;
    logic        sync_n = 1'b1, din_n = 1'b1, dout_n = 1'b1, wtbt_n = 1'b1, iaki_n = 1'b1;
    logic [15:0] tx_data;
    logic [1:0]  tx_stb;
    logic [15:0] rx_data = '0;
    logic [1:0]  rx_stb = '0;

    int ncmp = 0, nerr = 0;
    int stb0 = 0, stb1 = 0;
    logic [7:0] last1 = '0;
    logic [15:0] d;
    int n;

    qbus_dl11_mux #(.CHAN(2), .TX_DIV(TXD)) dut (
        .clk(clk), .rst(rst), .ad_n(ad_n), .ad_out_n(ad_out_n), .ad_oe(ad_oe),
        .sync_n(sync_n), .din_n(din_n), .dout_n(dout_n), .wtbt_n(wtbt_n),
        .rply_n(rply_n), .virq_n(virq_n), .iaki_n(iaki_n), .iako_n(iako_n),
        .tx_data(tx_data), .tx_stb(tx_stb), .rx_data(rx_data), .rx_stb(rx_stb)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_stb[0]) stb0++;
        if (tx_stb[1]) begin stb1++; last1 = tx_data[15:8]; end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %06o expected %06o", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] dv,
                            input bit rx_at = 1'b0, input logic [7:0] rb = 8'h00);
        int k;
        ad_n = ~a; sync_n = 1'b0;
        @(negedge clk);
        ad_n = '1; din_n = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (rply_n !== 1'b0 && k < 10);
        chk("rd_rply", rply_n, 0);
        chk("rd_oe", ad_oe, 1);
        dv = ~ad_out_n;
        din_n = 1'b1;
        if (rx_at) begin rx_data[7:0] = rb; rx_stb[0] = 1'b1; end
        @(negedge clk);
        rx_stb = '0;
        chk("rd_release", {ad_oe, rply_n}, 16'b01);
        sync_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] dv, input logic bw = 1'b1);
        int k;
        ad_n = ~a; sync_n = 1'b0;
        @(negedge clk);
        ad_n = ~dv; wtbt_n = bw; dout_n = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (rply_n !== 1'b0 && k < 10);
        chk("wr_rply", rply_n, 0);
        dout_n = 1'b1; wtbt_n = 1'b1;
        @(negedge clk);
        chk("wr_release", rply_n, 1);
        sync_n = 1'b1; ad_n = '1;
        @(negedge clk);
    endtask

    task automatic iak(output logic [15:0] dv);
        int k;
        iaki_n = 1'b0; din_n = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (rply_n !== 1'b0 && k < 10);
        chk("iak_rply", rply_n, 0);
        chk("iak_oe", ad_oe, 1);
        chk("iak_iako", iako_n, 1);
        dv = ~ad_out_n;
        din_n = 1'b1; iaki_n = 1'b1;
        @(negedge clk);
        chk("iak_release", {ad_oe, rply_n}, 16'b01);
    endtask

    task automatic rx0(input logic [7:0] b);
        rx_data[7:0] = b; rx_stb[0] = 1'b1;
        @(negedge clk);
        rx_stb = '0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rply", rply_n, 1);
        chk("rst_oe", ad_oe, 0);
        chk("rst_ad", ad_out_n, 16'hFFFF);
        chk("rst_virq", virq_n, 1);
        chk("rst_iako", iako_n, 1);
        chk("rst_stb", tx_stb, 0);
        rst = 1'b0;
        @(negedge clk);

        bus_read(16'o177564, d); chk("xcsr_reset", d, 16'o000200);
        bus_read(16'o177560, d); chk("rcsr_reset", d, 16'o000000);

        // Address just below the block
        ad_n = ~16'o177550; sync_n = 1'b0;
        @(negedge clk);
        din_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("unsel_oe", ad_oe, 0);
        chk("unsel_rply", rply_n, 1);
        din_n = 1'b1; sync_n = 1'b1; ad_n = '1;
        @(negedge clk);

        // TX pacing on channel 1
        bus_write(16'o177576, 16'o000101);
        chk("tx_stb_once", 16'(stb1), 1);
        chk("tx_byte", last1, 8'o101);
        repeat (11) @(negedge clk);
        bus_read(16'o177574, d); chk("xcsr_busy_last", d, 16'o000000);
        bus_write(16'o177576, 16'o000103);
        repeat (12) @(negedge clk);
        bus_read(16'o177574, d); chk("xcsr_ready_first", d, 16'o000200);
        bus_write(16'o177576, 16'o000105);
        bus_write(16'o177576, 16'o000107);
        repeat (7) @(negedge clk);
        bus_read(16'o177574, d); chk("xcsr_no_restart", d, 16'o000200);
        chk("tx_stb_total", 16'(stb1), 3);
        chk("tx_byte_kept", last1, 8'o105);
        chk("tx_stb_ch0", 16'(stb0), 0);

        // RX on channel 0
        rx0(8'h41);
        bus_read(16'o177560, d); chk("rcsr_done", d, 16'o000200);
        bus_read(16'o177562, d); chk("rbuf_byte", d, 16'o000101);
        bus_read(16'o177560, d); chk("rcsr_popped", d, 16'o000000);
        rx0(8'h41);
        rx0(8'h42);
`ifdef QBUS_DL11_MUX_RXFIFO_EN
        bus_read(16'o177562, d); chk("rbuf_fifo0", d, 16'o000101);
        bus_read(16'o177562, d); chk("rbuf_fifo1", d, 16'o000102);
`else
        bus_read(16'o177562, d); chk("rbuf_ovr", d, 16'o100102);
`endif
        bus_read(16'o177560, d); chk("rcsr_after_ovr", d, 16'o000000);
        rx0(8'h43);
        bus_read(16'o177562, d, 1'b1, 8'h44); chk("rbuf_pop_push", d, 16'o000103);
        bus_read(16'o177560, d); chk("rcsr_pop_push", d, 16'o000200);
        bus_read(16'o177562, d); chk("rbuf_no_ovr", d, 16'o000104);

        // Odd-byte write must leave XIE alone
        bus_write(16'o177565, 16'o000100, 1'b0);
        bus_read(16'o177564, d); chk("byte_wr_ignored", d, 16'o000200);
        chk("byte_wr_virq", virq_n, 1);

        // Interrupts
        bus_write(16'o177564, 16'o000100);
        bus_write(16'o177574, 16'o000100);
        chk("virq_active", virq_n, 0);
        bus_read(16'o177564, d); chk("xcsr_xie", d, 16'o000300);
        iak(d); chk("vec_ch0_tx", d, 16'o000064);
        @(negedge clk);
        iak(d); chk("vec_ch1_tx", d, 16'o000074);
        @(negedge clk);
        chk("virq_idle", virq_n, 1);

        // Daisy-chain pass-through
        iaki_n = 1'b0;
        @(negedge clk);
        chk("pass_iako", iako_n, 0);
        din_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("pass_oe", ad_oe, 0);
        chk("pass_rply", rply_n, 1);
        din_n = 1'b1; iaki_n = 1'b1;
        @(negedge clk);
        chk("pass_iako_off", iako_n, 1);

        // Reset in the middle of a read
        ad_n = ~16'o177564; sync_n = 1'b0;
        @(negedge clk);
        din_n = 1'b0; ad_n = '1;
        n = 0;
        do begin @(negedge clk); n++; end while (rply_n !== 1'b0 && n < 10);
        chk("mid_rply", rply_n, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rply", rply_n, 1);
        chk("mid_rst_oe", ad_oe, 0);
        rst = 1'b0; din_n = 1'b1; sync_n = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(16'o177564, d); chk("xcsr_after_rst", d, 16'o000200);
        chk("virq_after_rst", virq_n, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
